mux_dmx_loopback_ctrl: RTL and testbench



---
 rtl/mux_dmx_loopback_ctrl.sv | 143 ++++++++++++++
 tb/tb_mux_dmx_loopback_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_dmx_loopback_ctrl.sv
// Loopback sequencer for the combinational 8:1 MUX / 1:8 DMX pair: serialises a
// captured word through the MUX, rebuilds it from the DMX outputs and flags any mismatch.
module mux_dmx_loopback_ctrl #(
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       data_in,
  output logic             busy,
  output logic             done,
  output logic [2:0]       addr,
  output logic [7:0]       mux_in_data,
  input  logic             mux_out_data,
  output logic             dmx_in_data,
  input  logic [7:0]       dmx_out_data,
  output logic [7:0]       data_out,
  output logic             error,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0]       FIRST_ADDR  = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0]       LAST_ADDR   = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam state_t           BIT_ENTRY   = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q;
  logic [2:0]       addr_q;
  logic [7:0]       mux_in_data_q;
  logic             dmx_in_data_q;
  logic [7:0]       data_out_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             step_err_q;
  logic [3:0]       settle_cnt_q;

  logic [7:0]       data_out_d;
  logic             step_err_d;
  logic             fail_d;
  logic [2:0]       addr_next_d;

  // Result of the WRITE step; the final bit is folded in so error is valid with done.
  always_comb begin
    data_out_d         = data_out_q;
    data_out_d[addr_q] = dmx_out_data[addr_q];
    step_err_d         = step_err_q | (dmx_out_data != ({7'd0, dmx_in_data_q} << addr_q));
    fail_d             = step_err_d | (data_out_d != mux_in_data_q);
    addr_next_d        = (MSB_FIRST != 0) ? (addr_q - 3'd1) : (addr_q + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= 3'd0;
      mux_in_data_q <= 8'd0;
      dmx_in_data_q <= 1'b0;
      data_out_q    <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_cnt_q     <= '0;
      step_err_q    <= 1'b0;
      settle_cnt_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          addr_q <= 3'd0;
          if (start) begin
            mux_in_data_q <= data_in;
            data_out_q    <= 8'd0;
            step_err_q    <= 1'b0;
            error_q       <= 1'b0;
            addr_q        <= FIRST_ADDR;
            busy_q        <= 1'b1;
            settle_cnt_q  <= SETTLE_LOAD;
            state_q       <= BIT_ENTRY;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == 4'd0) begin
            state_q <= S_SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          dmx_in_data_q <= mux_out_data;
          state_q       <= S_WRITE;
        end
        S_WRITE: begin
          data_out_q <= data_out_d;
          step_err_q <= step_err_d;
          if (addr_q == LAST_ADDR) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= fail_d;
            if (fail_d && (err_cnt_q != ERR_MAX)) begin
              err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
            state_q <= S_DONE;
          end else begin
            addr_q       <= addr_next_d;
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= BIT_ENTRY;
          end
        end
        S_DONE: begin
          addr_q  <= 3'd0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          addr_q  <= 3'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign addr        = addr_q;
  assign mux_in_data = mux_in_data_q;
  assign dmx_in_data = dmx_in_data_q;
  assign data_out    = data_out_q;
  assign error       = error_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mux_dmx_loopback_ctrl.sv
// Directed bench: two sequencers (LSB-first and MSB-first) each looped through
// a behavioural MUX/DMX pair; instance A's DMX can have faults injected.
module tb_mux_dmx_loopback_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic [7:0] data_in_a, data_in_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] mux_in_a, mux_in_b;
  logic       mux_out_a, mux_out_b;
  logic       dmx_in_a, dmx_in_b;
  logic [7:0] dmx_out_a, dmx_out_b;
  logic [7:0] data_out_a, data_out_b;
  logic       error_a, error_b;
  logic [3:0] err_cnt_a, err_cnt_b;

  logic       stuck3, stray5;
  int         checks = 0;
  int         errors = 0;
  int         lat;
  int         dones;
  int         first_done;
  int         second_done;
  logic [2:0] addr_log [0:63];
  logic       busy_log [0:63];

  assign mux_out_a = mux_in_a[addr_a];
  assign mux_out_b = mux_in_b[addr_b];

  always_comb begin
    dmx_out_a = {7'd0, dmx_in_a} << addr_a;
    if (stuck3) dmx_out_a[3] = 1'b0;
    if (stray5 && (addr_a == 3'd5)) dmx_out_a[0] = 1'b1;
  end
  assign dmx_out_b = {7'd0, dmx_in_b} << addr_b;

  mux_dmx_loopback_ctrl #(.MSB_FIRST(0), .SETTLE_CYC(1), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_in_a),
    .busy(busy_a), .done(done_a), .addr(addr_a), .mux_in_data(mux_in_a),
    .mux_out_data(mux_out_a), .dmx_in_data(dmx_in_a), .dmx_out_data(dmx_out_a),
    .data_out(data_out_a), .error(error_a), .err_cnt(err_cnt_a)
  );

  mux_dmx_loopback_ctrl #(.MSB_FIRST(1), .SETTLE_CYC(1), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_in_b),
    .busy(busy_b), .done(done_b), .addr(addr_b), .mux_in_data(mux_in_b),
    .mux_out_data(mux_out_b), .dmx_in_data(dmx_in_b), .dmx_out_data(dmx_out_b),
    .data_out(data_out_b), .error(error_b), .err_cnt(err_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns with lat = cycles from accepted start to done.
  task automatic run_a(input logic [7:0] d);
    start_a = 1'b1;
    data_in_a = d;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (done_a !== 1'b1 && lat < 60) begin
      addr_log[lat] = addr_a;
      busy_log[lat] = busy_a;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_b(input logic [7:0] d);
    start_b = 1'b1;
    data_in_b = d;
    @(negedge clk);
    start_b = 1'b0;
    lat = 1;
    while (done_b !== 1'b1 && lat < 60) begin
      addr_log[lat] = addr_b;
      busy_log[lat] = busy_b;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    data_in_a = 8'd0;
    data_in_b = 8'd0;
    stuck3 = 1'b0;
    stray5 = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_addr", addr_a, 3'd0);
    chk("rst_mux_in", mux_in_a, 8'd0);
    chk("rst_dmx_in", dmx_in_a, 1'b0);
    chk("rst_data_out", data_out_a, 8'd0);
    chk("rst_error", error_a, 1'b0);
    chk("rst_err_cnt", err_cnt_a, 4'd0);
    chk("rst_b_addr", addr_b, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    // LSB-first transfer of 0xA5
    run_a(8'hA5);
    chk("a5_latency", lat, 25);
    chk("a5_done", done_a, 1'b1);
    chk("a5_busy_at_done", busy_a, 1'b0);
    chk("a5_data_out", data_out_a, 8'hA5);
    chk("a5_error", error_a, 1'b0);
    chk("a5_err_cnt", err_cnt_a, 4'd0);
    chk("a5_busy_first", busy_log[1], 1'b1);
    chk("a5_busy_last", busy_log[24], 1'b1);
    for (int p = 1; p <= 24; p++) chk("a5_addr_seq", addr_log[p], (p - 1) / 3);
    @(negedge clk);
    chk("a5_done_pulse_end", done_a, 1'b0);
    chk("a5_data_hold", data_out_a, 8'hA5);
    chk("a5_idle_addr", addr_a, 3'd0);

    // MSB-first transfer of 0x3C
    run_b(8'h3C);
    chk("3c_latency", lat, 25);
    chk("3c_data_out", data_out_b, 8'h3C);
    chk("3c_error", error_b, 1'b0);
    for (int p = 1; p <= 24; p++) chk("3c_addr_seq", addr_log[p], 7 - (p - 1) / 3);

    // start re-pulsed mid-transfer with different data must be ignored
    start_a = 1'b1;
    data_in_a = 8'h96;
    @(negedge clk);
    start_a = 1'b0;
    dones = 0;
    first_done = 0;
    for (int p = 1; p <= 40; p++) begin
      if (done_a === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = p;
      end
      if (p == 5) begin
        start_a = 1'b1;
        data_in_a = 8'h00;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_done_count", dones, 1);
    chk("ign_done_time", first_done, 25);
    chk("ign_data_out", data_out_a, 8'h96);
    chk("ign_mux_in", mux_in_a, 8'h96);
    chk("ign_error", error_a, 1'b0);

    // DMX line 3 stuck low
    stuck3 = 1'b1;
    run_a(8'hFF);
    chk("stuck_data_out", data_out_a, 8'hF7);
    chk("stuck_error", error_a, 1'b1);
    chk("stuck_err_cnt1", err_cnt_a, 4'd1);
    @(negedge clk);
    chk("stuck_error_held", error_a, 1'b1);
    run_a(8'hFF);
    chk("stuck_err_cnt2", err_cnt_a, 4'd2);
    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      run_a(8'hFF);
    end
    chk("stuck_err_cnt_sat", err_cnt_a, 4'd15);
    stuck3 = 1'b0;

    // stray DMX line 0 while addr=5
    @(negedge clk);
    stray5 = 1'b1;
    run_a(8'h20);
    chk("stray_data_out", data_out_a, 8'h20);
    chk("stray_error", error_a, 1'b1);
    chk("stray_err_cnt", err_cnt_a, 4'd15);
    stray5 = 1'b0;

    // reset at cycle 10 of a transfer
    @(negedge clk);
    start_a = 1'b1;
    data_in_a = 8'hC3;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_addr", addr_a, 3'd0);
    chk("abort_data_out", data_out_a, 8'd0);
    chk("abort_err_cnt", err_cnt_a, 4'd0);
    chk("abort_error", error_a, 1'b0);
    chk("abort_done", done_a, 1'b0);
    rst = 1'b0;
    dones = 0;
    for (int p = 0; p < 30; p++) begin
      if (done_a === 1'b1) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    run_a(8'h5A);
    chk("fresh_latency", lat, 25);
    chk("fresh_data_out", data_out_a, 8'h5A);
    chk("fresh_error", error_a, 1'b0);
    chk("fresh_err_cnt", err_cnt_a, 4'd0);

    // start held high: back-to-back transfers one IDLE cycle apart
    @(negedge clk);
    start_a = 1'b1;
    data_in_a = 8'h11;
    @(negedge clk);
    dones = 0;
    first_done = 0;
    second_done = 0;
    for (int p = 1; p <= 60; p++) begin
      if (done_a === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = p;
        else if (second_done == 0) second_done = p;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("b2b_first_done", first_done, 25);
    chk("b2b_second_done", second_done, 51);
    chk("b2b_done_count", dones, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
